// File: rtl/inta_sequencer.sv
// inta_sequencer: 8259-style INTA handshake that raises INT, acknowledges the
// winning level on the first INTA pulse and drives the vector on the second.
module inta_sequencer #(
    parameter int INTA_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       INTA_N,
    input  logic       REQ_VALID,
    input  logic [2:0] REQ_LEVEL,
    input  logic       AEOI,
    input  logic       ICW2_WR,
    input  logic [7:0] ICW2_DATA,
    output logic       INT,
    output logic       ACK1,
    output logic [2:0] ACK_LEVEL,
    output logic       ISR_CLR,
    output logic       SPURIOUS,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic       BUSY
);
    localparam int CW = (INTA_TIMEOUT < 2) ? 1 : $clog2(INTA_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, INT_PEND, ACK1_LOW, WAIT2, VEC_LOW} state_t;

    state_t          state_q, state_d;
    logic            inta_q, int_q, ack1_q, isr_clr_q, spurious_q, data_oe_q, spur_q;
    logic            inta_d, int_d, ack1_d, isr_clr_d, spurious_d, data_oe_d, spur_d;
    logic [2:0]      ack_level_q, ack_level_d;
    logic [4:0]      base_q, base_d;
    logic [7:0]      data_out_q, data_out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fall, rise, timeout, pend_fall, vec_fall;
    logic            unused_icw2_low;

    assign fall     = inta_q & ~INTA_N;
    assign rise     = ~inta_q & INTA_N;
    assign timeout  = cnt_q == CW'(INTA_TIMEOUT - 1);
    assign pend_fall = (state_q == INT_PEND) && fall;
    assign vec_fall  = (state_q == WAIT2) && fall;
    assign unused_icw2_low = ^ICW2_DATA[2:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            inta_q      <= 1'b1;
            int_q       <= 1'b0;
            ack1_q      <= 1'b0;
            isr_clr_q   <= 1'b0;
            spurious_q  <= 1'b0;
            data_oe_q   <= 1'b0;
            data_out_q  <= 8'h00;
            ack_level_q <= 3'd0;
            base_q      <= 5'd0;
            cnt_q       <= '0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_q      <= inta_d;
            int_q       <= int_d;
            ack1_q      <= ack1_d;
            isr_clr_q   <= isr_clr_d;
            spurious_q  <= spurious_d;
            data_oe_q   <= data_oe_d;
            data_out_q  <= data_out_d;
            ack_level_q <= ack_level_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            spur_q      <= spur_d;
        end
    end

    // A second-pulse fall wins over a timeout landing on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (REQ_VALID) state_d = INT_PEND;
            INT_PEND: if (fall) state_d = ACK1_LOW;
            ACK1_LOW: if (rise) state_d = WAIT2;
            WAIT2:    state_d = fall ? VEC_LOW : (timeout ? IDLE : WAIT2);
            VEC_LOW:  if (rise) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        inta_d      = INTA_N;
        int_d       = (state_d == INT_PEND) && REQ_VALID;
        ack1_d      = pend_fall && REQ_VALID;
        spurious_d  = pend_fall && !REQ_VALID;
        ack_level_d = pend_fall ? (REQ_VALID ? REQ_LEVEL : 3'd7) : ack_level_q;
        spur_d      = pend_fall ? !REQ_VALID : spur_q;
        base_d      = ICW2_WR ? ICW2_DATA[7:3] : base_q;
        cnt_d       = (state_q == ACK1_LOW && rise) ? '0 :
                      (state_q == WAIT2) ? cnt_q + CW'(1) : cnt_q;
        // base_d so an ICW2 write on the vector fall is already reflected
        data_out_d  = vec_fall ? {base_d, ack_level_q} : data_out_q;
        data_oe_d   = state_d == VEC_LOW;
        isr_clr_d   = (state_q == VEC_LOW) && rise && AEOI && !spur_q;
    end

    assign INT       = int_q;
    assign ACK1      = ack1_q;
    assign ACK_LEVEL = ack_level_q;
    assign ISR_CLR   = isr_clr_q;
    assign SPURIOUS  = spurious_q;
    assign DATA_OUT  = data_out_q;
    assign DATA_OE   = data_oe_q;
    assign BUSY      = state_q != IDLE;
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: directed INTA handshake scenarios with hand-computed
// pulses and vectors.
module tb_inta_sequencer;
    logic       CLK, RST_N, INTA_N, REQ_VALID, AEOI, ICW2_WR;
    logic [2:0] REQ_LEVEL;
    logic [7:0] ICW2_DATA;
    logic       INT, ACK1, ISR_CLR, SPURIOUS, DATA_OE, BUSY;
    logic [2:0] ACK_LEVEL;
    logic [7:0] DATA_OUT;
    int         n_chk = 0;
    int         n_pass = 0;

    inta_sequencer #(.INTA_TIMEOUT(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .INTA_N(INTA_N), .REQ_VALID(REQ_VALID),
        .REQ_LEVEL(REQ_LEVEL), .AEOI(AEOI), .ICW2_WR(ICW2_WR), .ICW2_DATA(ICW2_DATA),
        .INT(INT), .ACK1(ACK1), .ACK_LEVEL(ACK_LEVEL), .ISR_CLR(ISR_CLR),
        .SPURIOUS(SPURIOUS), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic icw2(input logic [7:0] d);
        ICW2_WR = 1'b1;
        ICW2_DATA = d;
        step();
        ICW2_WR = 1'b0;
    endtask

    // Full two-pulse sequence; spur drops REQ_VALID before the first fall
    task automatic seq(input logic [2:0] lvl, input logic aeoi, input logic spur,
                       input logic wr2, input logic [7:0] d2, input logic [7:0] vec);
        logic [2:0] exp_lvl;
        exp_lvl = spur ? 3'd7 : lvl;
        AEOI = aeoi;
        REQ_LEVEL = lvl;
        REQ_VALID = 1'b1;
        step();
        chk("int_rise", INT, 1);
        chk("busy_pend", BUSY, 1);
        if (spur) begin
            REQ_VALID = 1'b0;
            step();
            chk("int_drop", INT, 0);
        end
        INTA_N = 1'b0;
        step();
        chk("ack1", ACK1, !spur);
        chk("spurious", SPURIOUS, spur);
        chk("ack_level", ACK_LEVEL, exp_lvl);
        chk("oe_pulse1", DATA_OE, 0);
        chk("int_after_ack", INT, 0);
        REQ_VALID = 1'b0;
        step();
        chk("ack1_once", ACK1, 0);
        chk("spurious_once", SPURIOUS, 0);
        INTA_N = 1'b1;
        step();
        chk("oe_wait2", DATA_OE, 0);
        step();
        INTA_N = 1'b0;
        ICW2_WR = wr2;
        ICW2_DATA = d2;
        step();
        ICW2_WR = 1'b0;
        chk("oe_vec", DATA_OE, 1);
        chk("vector", DATA_OUT, vec);
        step();
        chk("oe_hold", DATA_OE, 1);
        chk("vector_hold", DATA_OUT, vec);
        INTA_N = 1'b1;
        step();
        chk("oe_end", DATA_OE, 0);
        chk("isr_clr", ISR_CLR, aeoi && !spur);
        chk("busy_end", BUSY, 0);
        chk("ack_level_held", ACK_LEVEL, exp_lvl);
        step();
        chk("isr_clr_once", ISR_CLR, 0);
    endtask

    initial begin
        RST_N = 1'b1; INTA_N = 1'b1; REQ_VALID = 1'b0; REQ_LEVEL = 3'd0;
        AEOI = 1'b0; ICW2_WR = 1'b0; ICW2_DATA = 8'h00;
        #3 RST_N = 1'b0;
        #1;
        chk("rst_int", INT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_oe", DATA_OE, 0);
        chk("rst_out", DATA_OUT, 8'h00);
        chk("rst_level", ACK_LEVEL, 0);
        chk("rst_pulses", {ACK1, ISR_CLR, SPURIOUS}, 0);
        step();
        step();
        RST_N = 1'b1;
        step();

        icw2(8'h40);
        seq(3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h43);
        seq(3'd5, 1'b1, 1'b0, 1'b0, 8'h00, 8'h45);
        seq(3'd5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h45);
        icw2(8'h08);
        seq(3'd4, 1'b1, 1'b1, 1'b0, 8'h00, 8'h0F);
        seq(3'd2, 1'b0, 1'b0, 1'b1, 8'hA8, 8'hAA);

        // INTA fall while idle is ignored
        INTA_N = 1'b0;
        step();
        chk("idle_fall_pulses", {ACK1, SPURIOUS, ISR_CLR}, 0);
        chk("idle_fall_busy", BUSY, 0);
        chk("idle_fall_oe", DATA_OE, 0);
        INTA_N = 1'b1;
        step();

        // Timeout after a single INTA pulse
        AEOI = 1'b1;
        REQ_LEVEL = 3'd6;
        REQ_VALID = 1'b1;
        step();
        INTA_N = 1'b0;
        step();
        chk("to_ack1", ACK1, 1);
        REQ_VALID = 1'b0;
        INTA_N = 1'b1;
        step();
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("to_busy", BUSY, 1);
            chk("to_oe", DATA_OE, 0);
        end
        step();
        chk("to_idle", BUSY, 0);
        chk("to_oe_end", DATA_OE, 0);
        chk("to_isr_clr", ISR_CLR, 0);
        step();
        chk("to_isr_clr2", ISR_CLR, 0);

        // Reset asserted while the vector is on the bus
        AEOI = 1'b1;
        icw2(8'h80);
        REQ_LEVEL = 3'd1;
        REQ_VALID = 1'b1;
        step();
        INTA_N = 1'b0;
        step();
        REQ_VALID = 1'b0;
        INTA_N = 1'b1;
        step();
        step();
        INTA_N = 1'b0;
        step();
        chk("rm_oe_before", DATA_OE, 1);
        chk("rm_vec_before", DATA_OUT, 8'h81);
        #2 RST_N = 1'b0;
        #1;
        chk("rm_oe_async", DATA_OE, 0);
        chk("rm_out_async", DATA_OUT, 8'h00);
        chk("rm_busy_async", BUSY, 0);
        INTA_N = 1'b1;
        step();
        chk("rm_isr_clr", ISR_CLR, 0);
        RST_N = 1'b1;
        step();
        chk("rm_int", INT, 0);
        chk("rm_level", ACK_LEVEL, 0);
        seq(3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have parameter INTA_TIMEOUT, default 255, meaning the maximum number of cycles between the first INTA rising edge and the second INTA falling edge.
REQ-002 SHALL have port CLK  input  1  the single system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port INTA_N  input  1  CPU interrupt-acknowledge strobe, active-low, synchronous to CLK.
REQ-005 SHALL have port REQ_VALID  input  1  from the priority block: an unmasked request outranks the current in-service level.
REQ-006 SHALL have port REQ_LEVEL  input  3  from the priority block: the winning IR level (0-7).
REQ-007 SHALL have port AEOI  input  1  automatic end-of-interrupt mode (from ICW4).
REQ-008 SHALL have port ICW2_WR  input  1  one-cycle strobe that loads the vector base.
REQ-009 SHALL have port ICW2_DATA  input  8  ICW2 byte; only bits [7:3] are used.
REQ-010 SHALL have port INT  output  1  interrupt request to the CPU.
REQ-011 SHALL have port ACK1  output  1  one-cycle pulse telling the priority block to set ISR and clear IRR at ACK_LEVEL.
REQ-012 SHALL have port ACK_LEVEL  output  3  the latched level, held stable from ACK1 until the next sequence.
REQ-013 SHALL have port ISR_CLR  output  1  one-cycle automatic-EOI pulse that clears ISR at ACK_LEVEL.
REQ-014 SHALL have port SPURIOUS  output  1  one-cycle pulse that flags a spurious acknowledge.
REQ-015 SHALL have port DATA_OUT  output  8  interrupt vector.
REQ-016 SHALL have port DATA_OE  output  1  data bus drive enable.
REQ-017 SHALL have port BUSY  output  1  high in every state except IDLE.

Function
REQ-018 SHALL register INTA_N into inta_q each cycle; a fall is detected when inta_q=1 and INTA_N=0, and a rise when inta_q=0 and INTA_N=1.
REQ-019 SHALL implement the FSM states IDLE, INT_PEND, ACK1_LOW, WAIT2, VEC_LOW.
REQ-020 SHALL transition IDLE -> INT_PEND when REQ_VALID=1, and SHALL register INT=1 in that same edge.
REQ-021 SHALL make INT equal to REQ_VALID, registered, while in INT_PEND, and SHALL hold INT=0 in all other states.
REQ-022 SHALL, on an INTA fall in INT_PEND with REQ_VALID=1, latch ACK_LEVEL=REQ_LEVEL, pulse ACK1 in the next cycle, and enter ACK1_LOW.
REQ-023 SHALL, on an INTA fall in INT_PEND with REQ_VALID=0, latch ACK_LEVEL=7, set the spur flag, pulse SPURIOUS instead of ACK1, and enter ACK1_LOW.
REQ-024 SHALL keep DATA_OE=0 during the first INTA pulse; on the INTA rise it SHALL enter WAIT2 and clear the timeout counter.
REQ-025 SHALL increment the counter in WAIT2; if the counter reaches INTA_TIMEOUT with no INTA fall, the FSM SHALL return to IDLE with no ISR_CLR.
REQ-026 SHALL, on an INTA fall in WAIT2, enter VEC_LOW and register DATA_OUT={base[7:3], ACK_LEVEL} with DATA_OE=1.
REQ-027 SHALL hold DATA_OE=1 and DATA_OUT stable in VEC_LOW until the INTA rise.
REQ-028 SHALL, on the INTA rise in VEC_LOW, drive DATA_OE=0 and return to IDLE; if AEOI=1 and the spur flag is clear, it SHALL pulse ISR_CLR in that same cycle.
REQ-029 SHALL load base[7:3] from ICW2_DATA on ICW2_WR in any state; if the load coincides with the INTA fall in WAIT2, the new base SHALL be used in the vector.
REQ-030 SHALL ignore an INTA fall that arrives in IDLE: no pulses, DATA_OE=0.
REQ-031 SHALL ignore REQ_VALID and REQ_LEVEL while the FSM is outside IDLE and INT_PEND.
REQ-032 SHALL evaluate a new REQ_VALID no earlier than the cycle after the FSM returns to IDLE; back-to-back sequences SHALL be allowed.

Reset
REQ-033 SHALL, while RST_N=0, immediately force: FSM=IDLE, inta_q=1, INT=0, ACK1=0, ISR_CLR=0, SPURIOUS=0, DATA_OE=0, DATA_OUT=8'h00, ACK_LEVEL=0, base=5'b00000, counter=0, spur flag=0, BUSY=0.
REQ-034 SHALL, on reset asserted mid-sequence, abort the sequence with no ISR_CLR, and DATA_OE SHALL fall asynchronously.

Verification
REQ-035 SHALL cover a normal sequence: ICW2=8'h40, REQ_VALID=1 with REQ_LEVEL=3, two INTA pulses -> INT rises, ACK1 pulses once with ACK_LEVEL=3, DATA_OUT=8'h43 with DATA_OE=1 only during the second pulse.
REQ-036 SHALL cover AEOI: AEOI=1 with level 5 -> ISR_CLR pulses on the second INTA rise with ACK_LEVEL=5; the same case with AEOI=0 -> no ISR_CLR.
REQ-037 SHALL cover a spurious acknowledge: REQ_VALID drops before the first INTA fall, ICW2=8'h08 -> SPURIOUS pulses, no ACK1, vector 8'h0F, no ISR_CLR even with AEOI=1.
REQ-038 SHALL cover the timeout: INTA_TIMEOUT=4, one INTA pulse only -> the FSM returns to IDLE 4 cycles after the rise, BUSY=0, DATA_OE never 1.
REQ-039 SHALL cover reset mid-operation: RST_N low during VEC_LOW -> DATA_OE=0 immediately; after release, INT=0 and base=0.
REQ-040 SHALL cover an ICW2 write coinciding with the second INTA fall: ICW2_DATA=8'hA8 with level 2 -> DATA_OUT=8'hAA.
